// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: ALU op classes, R-type funct
// codes, internal ALU function select and forwarding-source select.
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_fn_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] idx,
        input logic       ex_we,
        input logic [4:0] ex_reg,
        input logic       wb_we,
        input logic [4:0] wb_reg
    );
        if (ex_we && (ex_reg != 5'd0) && (ex_reg == idx))
            return FWD_MEM;
        else if (wb_we && (wb_reg != 5'd0) && (wb_reg == idx))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX fields, MEM/WB write-back bus, hazard flag and EX/MEM outputs
// seen by the execute stage.
interface ex_stage_if;
    import mips_pkg::*;

    logic        regDst, memRead, memtoReg, memWrite, aluSrc, regWrite;
    logic [1:0]  aluop;
    logic [31:0] read_data1, read_data2, sign_ext;
    logic [4:0]  reg_rs, reg_rt, reg_rd;
    logic [4:0]  if_id_rs, if_id_rt;
    logic        flush;
    logic        wb_regWrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;

    logic        load_use_stall;
    logic        memRead_out, memtoReg_out, memWrite_out, regWrite_out;
    logic [31:0] alu_result_out, write_data_out;
    logic [4:0]  write_reg_out;
    logic        zero_out;

    modport master (
        output regDst, memRead, memtoReg, memWrite, aluSrc, regWrite, aluop,
               read_data1, read_data2, sign_ext, reg_rs, reg_rt, reg_rd,
               if_id_rs, if_id_rt, flush, wb_regWrite, wb_write_reg, wb_write_data,
        input  load_use_stall, memRead_out, memtoReg_out, memWrite_out, regWrite_out,
               alu_result_out, write_data_out, write_reg_out, zero_out
    );

    modport slave (
        input  regDst, memRead, memtoReg, memWrite, aluSrc, regWrite, aluop,
               read_data1, read_data2, sign_ext, reg_rs, reg_rt, reg_rd,
               if_id_rs, if_id_rt, flush, wb_regWrite, wb_write_reg, wb_write_data,
        output load_use_stall, memRead_out, memtoReg_out, memWrite_out, regWrite_out,
               alu_result_out, write_data_out, write_reg_out, zero_out
    );

endinterface

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU: add/sub wrap, signed set-less-than, zero flag.
module ex_alu
    import mips_pkg::*;
(
    input  alu_fn_t     fn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    // Select operation; unknown selects fall back to add.
    always_comb begin
        result = '0;
        case (fn)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
            default: result = a + b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU control, destination select,
// load-use hazard detection and the EX/MEM pipeline register.
module ex_stage
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    ex_stage_if.slave bus
);

    fwd_sel_t    sel_a, sel_b;
    logic [31:0] op_a, fwd_b, op_b;
    alu_fn_t     fn;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic [4:0]  dest;

    // Forwarding muxes driven from the current EX/MEM and MEM/WB state.
    always_comb begin
        sel_a = fwd_select(bus.reg_rs, bus.regWrite_out, bus.write_reg_out,
                           bus.wb_regWrite, bus.wb_write_reg);
        sel_b = fwd_select(bus.reg_rt, bus.regWrite_out, bus.write_reg_out,
                           bus.wb_regWrite, bus.wb_write_reg);
        case (sel_a)
            FWD_MEM: op_a = bus.alu_result_out;
            FWD_WB:  op_a = bus.wb_write_data;
            default: op_a = bus.read_data1;
        endcase
        case (sel_b)
            FWD_MEM: fwd_b = bus.alu_result_out;
            FWD_WB:  fwd_b = bus.wb_write_data;
            default: fwd_b = bus.read_data2;
        endcase
        op_b = bus.aluSrc ? bus.sign_ext : fwd_b;
        dest = bus.regDst ? bus.reg_rd : bus.reg_rt;
    end

    // ALU control decode from aluop class and R-type funct.
    always_comb begin
        fn = ALU_ADD;
        case (bus.aluop)
            ALUOP_ADD: fn = ALU_ADD;
            ALUOP_SUB: fn = ALU_SUB;
            ALUOP_AND: fn = ALU_AND;
            default: begin
                case (bus.sign_ext[5:0])
                    FUNCT_ADD: fn = ALU_ADD;
                    FUNCT_SUB: fn = ALU_SUB;
                    FUNCT_AND: fn = ALU_AND;
                    FUNCT_OR:  fn = ALU_OR;
                    FUNCT_SLT: fn = ALU_SLT;
                    default:   fn = ALU_ADD;
                endcase
            end
        endcase
    end

    ex_alu u_alu (
        .fn     (fn),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // Load-use hazard back to decode; independent of flush.
    assign bus.load_use_stall = bus.memRead && (bus.reg_rt != 5'd0) &&
                                ((bus.reg_rt == bus.if_id_rs) || (bus.reg_rt == bus.if_id_rt));

    // EX/MEM register; flush turns the control bits into a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.memRead_out    <= 1'b0;
            bus.memtoReg_out   <= 1'b0;
            bus.memWrite_out   <= 1'b0;
            bus.regWrite_out   <= 1'b0;
            bus.alu_result_out <= '0;
            bus.write_data_out <= '0;
            bus.write_reg_out  <= '0;
            bus.zero_out       <= 1'b0;
        end else begin
            if (bus.flush) begin
                bus.memRead_out  <= 1'b0;
                bus.memtoReg_out <= 1'b0;
                bus.memWrite_out <= 1'b0;
                bus.regWrite_out <= 1'b0;
            end else begin
                bus.memRead_out  <= bus.memRead;
                bus.memtoReg_out <= bus.memtoReg;
                bus.memWrite_out <= bus.memWrite;
                bus.regWrite_out <= bus.regWrite;
            end
            bus.alu_result_out <= alu_res;
            bus.write_data_out <= fwd_b;
            bus.write_reg_out  <= dest;
            bus.zero_out       <= alu_zero;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver issues one ID/EX instruction per
// cycle and queues the reference result; a monitor compares after each edge.
module tb_ex_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        regDst, memRead, memtoReg, memWrite, aluSrc, regWrite, flush, wb_regWrite;
        logic [1:0]  aluop;
        logic [31:0] rd1, rd2, sext, wb_data;
        logic [4:0]  rs, rt, rd, if_rs, if_rt, wb_reg;
    } txn_t;

    typedef struct {
        logic        memRead, memtoReg, memWrite, regWrite, zero, flushed;
        logic [31:0] alu, wdata;
        logic [4:0]  wreg;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference copy of what EX/MEM currently holds (for forwarding).
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_alu;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic txn_t blank();
        txn_t t;
        t.regDst = 0; t.memRead = 0; t.memtoReg = 0; t.memWrite = 0; t.aluSrc = 0;
        t.regWrite = 0; t.flush = 0; t.wb_regWrite = 0; t.aluop = 2'b00;
        t.rd1 = 0; t.rd2 = 0; t.sext = 0; t.wb_data = 0;
        t.rs = 0; t.rt = 0; t.rd = 0; t.if_rs = 0; t.if_rt = 0; t.wb_reg = 0;
        return t;
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] regval, input txn_t t);
        if (m_we && idx != 0 && m_reg == idx) return m_alu;
        if (t.wb_regWrite && idx != 0 && t.wb_reg == idx) return t.wb_data;
        return regval;
    endfunction

    function automatic logic [31:0] alu_model(input txn_t t, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (t.aluop == 2'b01) return a - b;
        if (t.aluop == 2'b11) return a & b;
        if (t.aluop == 2'b10) begin
            if (t.sext[5:0] == 6'h22) return a - b;
            if (t.sext[5:0] == 6'h24) return a & b;
            if (t.sext[5:0] == 6'h25) return a | b;
            if (t.sext[5:0] == 6'h2a) return (sa < sb) ? 32'd1 : 32'd0;
        end
        return a + b;
    endfunction

    // Drive one instruction, queue its expected EX/MEM contents, check stall.
    task automatic issue(input txn_t t);
        exp_t e;
        logic [31:0] a, rtv, b;
        logic stall;
        bus.regDst = t.regDst; bus.memRead = t.memRead; bus.memtoReg = t.memtoReg;
        bus.memWrite = t.memWrite; bus.aluSrc = t.aluSrc; bus.regWrite = t.regWrite;
        bus.flush = t.flush; bus.aluop = t.aluop;
        bus.read_data1 = t.rd1; bus.read_data2 = t.rd2; bus.sign_ext = t.sext;
        bus.reg_rs = t.rs; bus.reg_rt = t.rt; bus.reg_rd = t.rd;
        bus.if_id_rs = t.if_rs; bus.if_id_rt = t.if_rt;
        bus.wb_regWrite = t.wb_regWrite; bus.wb_write_reg = t.wb_reg; bus.wb_write_data = t.wb_data;

        a   = src_val(t.rs, t.rd1, t);
        rtv = src_val(t.rt, t.rd2, t);
        b   = t.aluSrc ? t.sext : rtv;
        e.alu      = alu_model(t, a, b);
        e.zero     = (e.alu == 0);
        e.wdata    = rtv;
        e.wreg     = t.regDst ? t.rd : t.rt;
        e.flushed  = t.flush;
        e.memRead  = t.flush ? 1'b0 : t.memRead;
        e.memtoReg = t.flush ? 1'b0 : t.memtoReg;
        e.memWrite = t.flush ? 1'b0 : t.memWrite;
        e.regWrite = t.flush ? 1'b0 : t.regWrite;
        q.push_back(e);
        m_we  = e.regWrite;
        m_reg = e.wreg;
        m_alu = e.alu;

        stall = t.memRead && t.rt != 0 && (t.rt == t.if_rs || t.rt == t.if_rt);
        #1;
        chk("load_use_stall", 96'(bus.load_use_stall), 96'(stall));
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the EX/MEM register against the oldest queued entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                chk("ctrl", 96'({bus.memRead_out, bus.memtoReg_out, bus.memWrite_out, bus.regWrite_out}),
                    96'({e.memRead, e.memtoReg, e.memWrite, e.regWrite}));
                if (!e.flushed) begin
                    chk("alu_result_out", 96'(bus.alu_result_out), 96'(e.alu));
                    chk("write_data_out", 96'(bus.write_data_out), 96'(e.wdata));
                    chk("write_reg_out", 96'(bus.write_reg_out), 96'(e.wreg));
                    chk("zero_out", 96'(bus.zero_out), 96'(e.zero));
                end
            end
        end
    end

    initial begin
        txn_t t;
        logic [5:0] functs [6];
        functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
        functs[3] = 6'h25; functs[4] = 6'h2a; functs[5] = 6'h07;
        m_we = 0; m_reg = 0; m_alu = 0;
        issue(blank());
        void'(q.pop_front());
        tests--;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 96'({bus.alu_result_out, bus.write_data_out, bus.write_reg_out, bus.zero_out,
                                  bus.memRead_out, bus.memtoReg_out, bus.memWrite_out, bus.regWrite_out}), 96'd0);

        // R-type add r8 = r3(5) + r4(7)
        @(negedge clk);
        reset = 0;
        t = blank();
        t.aluop = 2'b10; t.sext = 32'h20; t.rs = 3; t.rd1 = 5; t.rt = 4; t.rd2 = 7;
        t.regDst = 1; t.rd = 8; t.regWrite = 1;
        issue(t);
        after_edge();
        chk("add_result", 96'(bus.alu_result_out), 96'd12);
        chk("add_wreg", 96'(bus.write_reg_out), 96'd8);
        chk("add_regwrite", 96'(bus.regWrite_out), 96'd1);
        chk("add_zero", 96'(bus.zero_out), 96'd0);

        // sub with rs=8 present in both EX/MEM (12) and MEM/WB (99)
        @(negedge clk);
        t = blank();
        t.aluop = 2'b01; t.rs = 8; t.rd1 = 0; t.rt = 9; t.rd2 = 2; t.regWrite = 1;
        t.wb_regWrite = 1; t.wb_reg = 8; t.wb_data = 99;
        issue(t);
        after_edge();
        chk("fwd_exmem_priority", 96'(bus.alu_result_out), 96'd10);

        // op writing r0, then same sub: r0 in EX/MEM must not forward
        @(negedge clk);
        t = blank();
        t.rs = 1; t.rd1 = 1; t.rt = 2; t.rd2 = 2; t.regDst = 1; t.rd = 0; t.regWrite = 1;
        issue(t);
        @(negedge clk);
        t = blank();
        t.aluop = 2'b01; t.rs = 8; t.rd1 = 0; t.rt = 9; t.rd2 = 2; t.regWrite = 1;
        t.wb_regWrite = 1; t.wb_reg = 8; t.wb_data = 99;
        issue(t);
        after_edge();
        chk("fwd_wb_r0_exmem", 96'(bus.alu_result_out), 96'd97);

        // lw r5, -4(r1=0x100) with decode reading r5
        @(negedge clk);
        t = blank();
        t.aluSrc = 1; t.sext = 32'hFFFF_FFFC; t.rs = 1; t.rd1 = 32'h100; t.rt = 5;
        t.memRead = 1; t.memtoReg = 1; t.regWrite = 1; t.if_rs = 5; t.if_rt = 3;
        issue(t);
        after_edge();
        chk("lw_addr", 96'(bus.alu_result_out), 96'h0FC);
        chk("stall_hit", 96'(bus.load_use_stall), 96'd1);

        // sw r6, 4(r1) with r6 coming from MEM/WB
        @(negedge clk);
        t = blank();
        t.aluSrc = 1; t.sext = 32'd4; t.rs = 1; t.rd1 = 32'h200; t.rt = 6; t.rd2 = 0;
        t.memWrite = 1; t.wb_regWrite = 1; t.wb_reg = 6; t.wb_data = 32'hDEAD;
        issue(t);
        after_edge();
        chk("sw_wdata", 96'(bus.write_data_out), 96'hDEAD);

        // load to r0 never stalls; non-matching load doesn't stall
        @(negedge clk);
        t = blank();
        t.memRead = 1; t.rt = 0; t.if_rs = 0; t.if_rt = 0;
        issue(t);
        after_edge();
        chk("stall_r0", 96'(bus.load_use_stall), 96'd0);
        @(negedge clk);
        t = blank();
        t.memRead = 1; t.rt = 5; t.if_rs = 1; t.if_rt = 2;
        issue(t);
        after_edge();
        chk("stall_nomatch", 96'(bus.load_use_stall), 96'd0);

        // flush kills the control bits
        @(negedge clk);
        t = blank();
        t.flush = 1; t.regWrite = 1; t.memWrite = 1; t.memRead = 1; t.memtoReg = 1; t.rt = 7;
        issue(t);
        after_edge();
        chk("flush_ctrl", 96'({bus.memRead_out, bus.memtoReg_out, bus.memWrite_out, bus.regWrite_out}), 96'd0);

        // slt -1 < 1
        @(negedge clk);
        t = blank();
        t.aluop = 2'b10; t.sext = 32'h2a; t.rs = 1; t.rd1 = 32'hFFFF_FFFF; t.rt = 2; t.rd2 = 1;
        t.regDst = 1; t.rd = 3; t.regWrite = 1;
        issue(t);
        after_edge();
        chk("slt_signed", 96'(bus.alu_result_out), 96'd1);

        // Asynchronous reset mid-cycle with nonzero state, held across two edges
        #1;
        reset = 1;
        #1;
        chk("async_reset", 96'({bus.alu_result_out, bus.write_reg_out, bus.regWrite_out}), 96'd0);
        m_we = 0; m_reg = 0; m_alu = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_hold", 96'({bus.alu_result_out, bus.write_data_out, bus.write_reg_out, bus.zero_out,
                                   bus.memRead_out, bus.memtoReg_out, bus.memWrite_out, bus.regWrite_out}), 96'd0);
        end

        // Randomised traffic with small register indices to provoke forwarding
        @(negedge clk);
        reset = 0;
        for (int n = 0; n < 400; n++) begin
            t = blank();
            t.regDst = 1'($urandom); t.memRead = ($urandom_range(0, 3) == 0);
            t.memtoReg = 1'($urandom); t.memWrite = 1'($urandom);
            t.aluSrc = ($urandom_range(0, 3) == 0); t.regWrite = ($urandom_range(0, 3) != 0);
            t.flush = ($urandom_range(0, 9) == 0); t.aluop = 2'($urandom);
            t.rd1 = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 20)) : $urandom;
            t.rd2 = ($urandom_range(0, 3) == 0) ? t.rd1 : $urandom;
            t.sext = {$urandom() & 32'hFFFF_FFC0} | {26'd0, functs[$urandom_range(0, 5)]};
            t.rs = 5'($urandom_range(0, 7)); t.rt = 5'($urandom_range(0, 7));
            t.rd = 5'($urandom_range(0, 7)); t.if_rs = 5'($urandom_range(0, 7));
            t.if_rt = 5'($urandom_range(0, 7));
            t.wb_regWrite = 1'($urandom); t.wb_reg = 5'($urandom_range(0, 7));
            t.wb_data = $urandom;
            issue(t);
            @(negedge clk);
        end

        for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipelined MIPS core: the consumer end of the ID/EX pipeline register. It takes the registered control and operand fields issued by decode and resolves data forwarding from EX/MEM and MEM/WB. It then decodes ALU control, selects the destination register, computes the ALU result and registers everything into the EX/MEM boundary. It also flags load-use hazards back to decode.

## Interface
Parameters:
- none; widths are fixed (32-bit datapath, 5-bit register index).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears the EX/MEM register.
- regDst, memRead, memtoReg, memWrite, aluSrc, regWrite  in  1 each  control bits from ID/EX.
- aluop  in  2  ALU operation class from ID/EX.
- read_data1, read_data2  in  32  register operands from ID/EX.
- sign_ext  in  32  sign-extended immediate; bits [5:0] carry funct.
- reg_rs, reg_rt, reg_rd  in  5 each  register indices from ID/EX.
- if_id_rs, if_id_rt  in  5 each  source indices of the instruction now in decode.
- flush  in  1  synchronous; next edge loads a bubble into EX/MEM.
- wb_regWrite  in  1  MEM/WB write enable.
- wb_write_reg  in  5  MEM/WB destination index.
- wb_write_data  in  32  MEM/WB result (after memtoReg mux).
- load_use_stall  out  1  combinational hazard flag to decode/PC.
- memRead_out, memtoReg_out, memWrite_out, regWrite_out  out  1 each  EX/MEM control.
- alu_result_out  out  32  EX/MEM ALU result.
- write_data_out  out  32  EX/MEM store data (forwarded rt).
- write_reg_out  out  5  EX/MEM destination index.
- zero_out  out  1  EX/MEM ALU zero flag.

## Operation
- Forward A (rs), Forward B (rt), each evaluated independently:
  - Source 1: EX/MEM when regWrite_out=1, write_reg_out≠0 and write_reg_out equals the index. This source has priority.
  - Source 2: MEM/WB when wb_regWrite=1, wb_write_reg≠0 and wb_write_reg equals the index.
  - Otherwise: read_data1 / read_data2.
- Operand B is sign_ext when aluSrc=1, else forwarded rt. write_data is always forwarded rt.
- ALU control:
  - aluop 00 → add.
  - aluop 01 → sub.
  - aluop 11 → and.
  - aluop 10 → funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed). Any other funct → add.
- Arithmetic: 32-bit wrap-around, no overflow trap. slt yields 32'd1 or 32'd0. zero = (result == 0).
- Destination: reg_rd when regDst=1, else reg_rt.
- load_use_stall = memRead & (reg_rt≠0) & (reg_rt==if_id_rs | reg_rt==if_id_rt). Purely combinational, independent of flush.

## Timing
- Reset (async): every registered output goes to 0 immediately and stays 0 while reset is high.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- flush=1 at an edge: memRead_out, memtoReg_out, memWrite_out and regWrite_out load 0. Datapath outputs load normally (don't-care). flush takes precedence over normal capture.
- Forwarding uses the current registered outputs, so a back-to-back dependency (distance 1) forwards from EX/MEM in the same cycle.
- Same index in both EX/MEM and MEM/WB: EX/MEM wins.
- Reset release mid-stream: first capture is on the first rising edge with reset low.

## Structure
- Shared package `mips_pkg`:
  - aluop encodings (ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10, ALUOP_AND=2'b11).
  - funct constants.
  - 3-bit ALU-function enum.
  - forward-select constants (FWD_REG, FWD_MEM, FWD_WB).
- Sub-module `ex_alu`: combinational ALU taking the enum and two 32-bit operands, returning result and zero.
- Forwarding muxes, ALU control decode, the hazard check and the EX/MEM register live in `ex_stage`.

## Test plan
- Reset: assert reset mid-cycle with nonzero captured state → all outputs 0 asynchronously; hold across two edges.
- R-type add, aluop=10, funct=100000, rs=3 (5), rt=4 (7), regDst=1, rd=8, regWrite=1 → after one edge: alu_result_out=12, write_reg_out=8, regWrite_out=1, zero_out=0.
- Double forwarding:
  - Prior op writes r8=12 (in EX/MEM); MEM/WB also writes r8=99; next sub with rs=8 and read_data1=0 → uses 12 (EX/MEM priority).
  - Same case with EX/MEM targeting r0 → uses 99.
- lw/sw: aluop=00, aluSrc=1, sign_ext=0xFFFFFFFC, rs=0x100 → alu_result_out=0xFC. sw forwards rt from MEM/WB into write_data_out.
- Load-use: memRead=1, reg_rt=5, if_id_rs=5 → load_use_stall=1. reg_rt=0 or no match → 0.
- flush=1 with regWrite=1, memWrite=1 → after edge, all four control outputs 0. slt with -1 vs 1 → alu_result_out=1.
